// File: rtl/priority_encoder8to3_if.sv
// Request/code bundle between event sources, the 8-to-3 priority encoder and its consumer.
// OVR exists only when ENC_OVERRUN_EN is defined.
interface priority_encoder8to3_if;
  logic       EN;
  logic [7:0] D;
  logic [2:0] A;
  logic       VALID;
  logic       READY;
  logic [7:0] PEND;
`ifdef ENC_OVERRUN_EN
  logic       OVR;

  modport master (output EN, D, READY, input A, VALID, PEND, OVR);
  modport slave  (input EN, D, READY, output A, VALID, PEND, OVR);
`else
  modport master (output EN, D, READY, input A, VALID, PEND);
  modport slave  (input EN, D, READY, output A, VALID, PEND);
`endif
endinterface

// File: rtl/priority_encoder8to3.sv
// Sequential 8-to-3 priority encoder: latches request pulses and hands out their indices over
// VALID/READY. Optional sticky overrun flag OVR is enabled by defining ENC_OVERRUN_EN.
module priority_encoder8to3 #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  priority_encoder8to3_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StPresent} stateT;

  stateT      stateQ;
  logic [7:0] pendQ;
  logic [7:0] pendD;
  logic [7:0] clrMask;
  logic [7:0] setMask;
  logic [2:0] aQ;
  logic       validQ;
  logic [2:0] sel;

  always_comb begin
    clrMask = 8'h00;
    if (validQ && bus.READY) begin
      clrMask[aQ] = 1'b1;
    end
    setMask = bus.EN ? bus.D : 8'h00;
    // Set is applied after clear so a re-request of the acknowledged bit survives.
    pendD   = (pendQ & ~clrMask) | setMask;
  end

  // Later loop iterations overwrite earlier ones, so the scan order decides who wins.
  always_comb begin
    sel = 3'd0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (pendD[i]) sel = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pendD[i]) sel = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
      pendQ  <= 8'h00;
      aQ     <= 3'd0;
      validQ <= 1'b0;
    end else begin
      pendQ <= pendD;
      unique case (stateQ)
        StIdle: begin
          if (pendD != 8'h00) begin
            aQ     <= sel;
            validQ <= 1'b1;
            stateQ <= StPresent;
          end else begin
            aQ     <= 3'd0;
            validQ <= 1'b0;
          end
        end
        StPresent: begin
          // Without a handshake the presented code is frozen; no preemption.
          if (bus.READY) begin
            if (pendD != 8'h00) begin
              aQ     <= sel;
              validQ <= 1'b1;
            end else begin
              aQ     <= 3'd0;
              validQ <= 1'b0;
              stateQ <= StIdle;
            end
          end
        end
        default: begin
          stateQ <= StIdle;
          aQ     <= 3'd0;
          validQ <= 1'b0;
        end
      endcase
    end
  end

`ifdef ENC_OVERRUN_EN
  logic ovrQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovrQ <= 1'b0;
    end else if ((setMask & pendQ & ~clrMask) != 8'h00) begin
      ovrQ <= 1'b1;
    end
  end

  assign bus.OVR = ovrQ;
`endif

  assign bus.A     = aQ;
  assign bus.VALID = validQ;
  assign bus.PEND  = pendQ;

endmodule

// File: tb/tb_priority_encoder8to3.sv
// Bench for priority_encoder8to3: one instance per priority direction, shared stimulus,
// vector table with a scoreboard queue plus a hand-written drain sequence.
module tb_priority_encoder8to3;

  logic clk;
  logic rst;

  priority_encoder8to3_if busHi ();
  priority_encoder8to3_if busLo ();

  priority_encoder8to3 #(.PRIO_HIGH(1'b1)) dutHi (.clk(clk), .rst(rst), .bus(busHi));
  priority_encoder8to3 #(.PRIO_HIGH(1'b0)) dutLo (.clk(clk), .rst(rst), .bus(busLo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic       ready;
    logic [7:0] pendHi;
    logic [2:0] aHi;
    logic       vHi;
    logic [7:0] pendLo;
    logic [2:0] aLo;
    logic       vLo;
    logic       ovr;
  } vecT;

  vecT      vecs[$];
  vecT      expQ[$];
  logic [2:0] codeHiQ[$];
  logic [2:0] codeLoQ[$];
  int       checks;
  int       errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic en, input logic [7:0] d, input logic ready,
                     input logic [7:0] pH, input logic [2:0] aH, input logic vH,
                     input logic [7:0] pL, input logic [2:0] aL, input logic vL,
                     input logic ovr);
    vecT v;
    v = '{rst: r, en: en, d: d, ready: ready, pendHi: pH, aHi: aH, vHi: vH,
          pendLo: pL, aLo: aL, vLo: vL, ovr: ovr};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic en, input logic [7:0] d, input logic ready);
    rst         = r;
    busHi.EN    = en;
    busLo.EN    = en;
    busHi.D     = d;
    busLo.D     = d;
    busHi.READY = ready;
    busLo.READY = ready;
  endtask

  initial begin
    vecT e;
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    //   rst en  d      rdy  pendHi aHi vHi  pendLo aLo vLo  ovr
    add(1'b1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1'b0, 1, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    // A5 pulse drained with READY high
    add(1'b0, 1, 8'hA5, 1, 8'hA5, 7, 1, 8'hA5, 0, 1, 0);
    add(1'b0, 1, 8'h00, 1, 8'h25, 5, 1, 8'hA4, 2, 1, 0);
    add(1'b0, 1, 8'h00, 1, 8'h05, 2, 1, 8'hA0, 5, 1, 0);
    add(1'b0, 1, 8'h00, 1, 8'h01, 0, 1, 8'h80, 7, 1, 0);
    add(1'b0, 1, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    add(1'b0, 1, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    // No preemption while stalled
    add(1'b0, 1, 8'h04, 0, 8'h04, 2, 1, 8'h04, 2, 1, 0);
    add(1'b0, 1, 8'h80, 0, 8'h84, 2, 1, 8'h84, 2, 1, 0);
    add(1'b0, 1, 8'h00, 0, 8'h84, 2, 1, 8'h84, 2, 1, 0);
    add(1'b0, 1, 8'h00, 1, 8'h80, 7, 1, 8'h80, 7, 1, 0);
    add(1'b0, 1, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    // Re-request during handshake keeps the bit; not an overrun
    add(1'b0, 1, 8'h08, 0, 8'h08, 3, 1, 8'h08, 3, 1, 0);
    add(1'b0, 1, 8'h08, 1, 8'h08, 3, 1, 8'h08, 3, 1, 0);
    add(1'b0, 1, 8'h00, 0, 8'h08, 3, 1, 8'h08, 3, 1, 0);
    // EN low blocks capture but draining continues
    add(1'b0, 0, 8'hFF, 0, 8'h08, 3, 1, 8'h08, 3, 1, 0);
    add(1'b0, 0, 8'hFF, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    // Reset drops a presented request and ignores D
    add(1'b0, 1, 8'hF0, 0, 8'hF0, 7, 1, 8'hF0, 4, 1, 0);
    add(1'b1, 1, 8'hFF, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    add(1'b0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    // Duplicate request on a pending bit merges and flags overrun
    add(1'b0, 1, 8'h10, 0, 8'h10, 4, 1, 8'h10, 4, 1, 0);
    add(1'b0, 1, 8'h10, 0, 8'h10, 4, 1, 8'h10, 4, 1, 1);
    add(1'b0, 1, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    add(1'b1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].ready);
      expQ.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      check($sformatf("row%0d pendHi", i), 32'(busHi.PEND), 32'(e.pendHi));
      check($sformatf("row%0d aHi", i), 32'(busHi.A), 32'(e.aHi));
      check($sformatf("row%0d validHi", i), 32'(busHi.VALID), 32'(e.vHi));
      check($sformatf("row%0d pendLo", i), 32'(busLo.PEND), 32'(e.pendLo));
      check($sformatf("row%0d aLo", i), 32'(busLo.A), 32'(e.aLo));
      check($sformatf("row%0d validLo", i), 32'(busLo.VALID), 32'(e.vLo));
`ifdef ENC_OVERRUN_EN
      check($sformatf("row%0d ovrHi", i), 32'(busHi.OVR), 32'(e.ovr));
      check($sformatf("row%0d ovrLo", i), 32'(busLo.OVR), 32'(e.ovr));
`endif
    end

    // Full-width pulse with READY held: eight codes on eight consecutive cycles.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      codeHiQ.push_back(3'(7 - i));
      codeLoQ.push_back(3'(i));
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (busHi.VALID) begin
        if (codeHiQ.size() == 0) check("drainHi extra code", 32'(busHi.A), 32'hFFFF);
        else check($sformatf("drainHi cyc%0d", cyc), 32'(busHi.A), 32'(codeHiQ.pop_front()));
      end else if (codeHiQ.size() != 0) begin
        check($sformatf("drainHi bubble cyc%0d", cyc), 32'(busHi.VALID), 32'd1);
      end
      if (busLo.VALID) begin
        if (codeLoQ.size() == 0) check("drainLo extra code", 32'(busLo.A), 32'hFFFF);
        else check($sformatf("drainLo cyc%0d", cyc), 32'(busLo.A), 32'(codeLoQ.pop_front()));
      end else if (codeLoQ.size() != 0) begin
        check($sformatf("drainLo bubble cyc%0d", cyc), 32'(busLo.VALID), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    check("drainHi leftover", 32'(codeHiQ.size()), 32'd0);
    check("drainLo leftover", 32'(codeLoQ.size()), 32'd0);
    check("drainHi pend empty", 32'(busHi.PEND), 32'h00);
    check("drainLo pend empty", 32'(busLo.PEND), 32'h00);
    check("drainHi idle A", 32'(busHi.A), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
